// File: rtl/issue_pkg.sv
// Shared types for the issue stage: FSM state encoding and the latched instruction packet.
package issue_pkg;

    localparam int ISSUE_NUM_REGS  = 8;
    localparam int ISSUE_PAYLOAD_W = 32;
    localparam int REG_IDX_W       = $clog2(ISSUE_NUM_REGS);

    typedef enum logic [2:0] {
        IDLE,
        CHK_RS1,
        CHK_RS2,
        CHK_RD,
        MARK,
        ISSUE
    } issue_state_t;

    typedef struct packed {
        logic [REG_IDX_W-1:0]       rs1;
        logic [REG_IDX_W-1:0]       rs2;
        logic [REG_IDX_W-1:0]       rd;
        logic                       uses_rs1;
        logic                       uses_rs2;
        logic                       writes_rd;
        logic [ISSUE_PAYLOAD_W-1:0] payload;
    } issue_pkt_t;

endpackage

// File: rtl/issue_ctrl.sv
// Issue stage: serially checks rs1/rs2/rd against a toggle-bit scoreboard, marks rd, then issues.
// Optional macro ISSUE_STALL_CNT_EN adds a saturating 32-bit stall_cnt output.
module issue_ctrl
    import issue_pkg::*;
#(
    parameter int NUM_REGS  = 8,
    parameter int PAYLOAD_W = 32
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [$clog2(NUM_REGS)-1:0] in_rs1,
    input  logic [$clog2(NUM_REGS)-1:0] in_rs2,
    input  logic [$clog2(NUM_REGS)-1:0] in_rd,
    input  logic                        in_uses_rs1,
    input  logic                        in_uses_rs2,
    input  logic                        in_writes_rd,
    input  logic [PAYLOAD_W-1:0]        in_payload,

    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [PAYLOAD_W-1:0]        out_payload,
    output logic [$clog2(NUM_REGS)-1:0] out_rd,
    output logic                        out_writes_rd,

    input  logic                        wb_valid,
    input  logic [$clog2(NUM_REGS)-1:0] wb_rd,

    output logic [$clog2(NUM_REGS)-1:0] sb_r_index,
    input  logic                        sb_score,
    output logic                        sb_w_en,
    output logic [$clog2(NUM_REGS)-1:0] sb_w_index
`ifdef ISSUE_STALL_CNT_EN
    ,
    output logic [31:0]                 stall_cnt
`endif
);

    localparam int IW = $clog2(NUM_REGS);

    // The packet struct is sized by the package, so the instance must agree with it.
    if (NUM_REGS != ISSUE_NUM_REGS || PAYLOAD_W != ISSUE_PAYLOAD_W) begin : g_cfg_check
        $error("issue_ctrl: NUM_REGS/PAYLOAD_W must match issue_pkg");
    end

    issue_state_t  state_q, state_d;
    issue_pkt_t    pkt_q, pkt_d;

    logic [IW-1:0] chk_idx;
    logic          chk_use;
    logic          hazard;
    logic          mark_need;
    logic          mark_fire;
    logic          wb_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        pkt_q <= pkt_d;
    end

    // Operand under test this cycle; register 0 and unused operands never stall.
    always_comb begin
        chk_idx = '0;
        chk_use = 1'b0;
        case (state_q)
            CHK_RS1: begin
                chk_idx = pkt_q.rs1;
                chk_use = pkt_q.uses_rs1;
            end
            CHK_RS2: begin
                chk_idx = pkt_q.rs2;
                chk_use = pkt_q.uses_rs2;
            end
            CHK_RD: begin
                chk_idx = pkt_q.rd;
                chk_use = pkt_q.writes_rd;
            end
            default: begin
                chk_idx = '0;
                chk_use = 1'b0;
            end
        endcase
    end

    assign hazard    = chk_use && (chk_idx != '0) && sb_score;
    assign mark_need = pkt_q.writes_rd && (pkt_q.rd != '0);
    assign wb_hit    = wb_valid && (wb_rd != '0);
    assign mark_fire = (state_q == MARK) && mark_need && !wb_valid && !rst;

    always_comb begin
        state_d = state_q;
        pkt_d   = pkt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    pkt_d.rs1       = in_rs1;
                    pkt_d.rs2       = in_rs2;
                    pkt_d.rd        = in_rd;
                    pkt_d.uses_rs1  = in_uses_rs1;
                    pkt_d.uses_rs2  = in_uses_rs2;
                    pkt_d.writes_rd = in_writes_rd;
                    pkt_d.payload   = in_payload;
                    state_d         = CHK_RS1;
                end
            end
            CHK_RS1: if (!hazard) state_d = CHK_RS2;
            CHK_RS2: if (!hazard) state_d = CHK_RD;
            CHK_RD:  if (!hazard) state_d = MARK;
            MARK: begin
                // Writeback owns the single write port, so the mark waits for a free cycle.
                if (!mark_need || !wb_valid) state_d = ISSUE;
            end
            ISSUE:   if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign in_ready      = (state_q == IDLE);
    assign out_valid     = (state_q == ISSUE);
    assign out_payload   = out_valid ? pkt_q.payload   : '0;
    assign out_rd        = out_valid ? pkt_q.rd        : '0;
    assign out_writes_rd = out_valid ? pkt_q.writes_rd : 1'b0;

    assign sb_r_index = chk_idx;
    assign sb_w_en    = wb_hit || mark_fire;
    assign sb_w_index = wb_hit ? wb_rd : (mark_fire ? pkt_q.rd : '0);

`ifdef ISSUE_STALL_CNT_EN
    logic        stall;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    assign stall = hazard || ((state_q == MARK) && mark_need && wb_valid);

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
